// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared kind/state encodings and trace entry width for trace_capture
package trace_pkg;

    localparam logic [1:0] KIND_NOP  = 2'd0;
    localparam logic [1:0] KIND_REG  = 2'd1;
    localparam logic [1:0] KIND_MEM  = 2'd2;
    localparam logic [1:0] KIND_HALT = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Entry layout: {kind[1:0], inum[cnt_w], pc[data_w], reg[reg_w], a[data_w], b[data_w]}
    function automatic int entry_w(input int data_w, input int reg_w, input int cnt_w);
        return 2 + cnt_w + 3 * data_w + reg_w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - trace buffer with overwrite-oldest or drop-newest behaviour when full
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wrap,
    input  logic             s_tvalid,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             do_pop;
    logic             do_write;
    logic             adv_rd;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = m_tready & ~empty;
    assign do_write = s_tvalid & (~full | do_pop | wrap);
    // A wrapping write into a full buffer consumes the oldest slot, so the head moves too.
    assign adv_rd   = do_pop | (s_tvalid & full & wrap);
    assign overflow = s_tvalid & full & ~do_pop;

    assign m_tvalid = ~empty;
    assign m_tdata  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (adv_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_write && !do_pop && !full) begin
                count <= count + (AW+1)'(1);
            end else if (do_pop && !do_write) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - retire-trace capture: classify commits, buffer entries, run/drain/done control
module trace_capture
    import trace_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int REG_W   = 4,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 100000,
    localparam int ENTRY_W = entry_w(DATA_W, REG_W, CNT_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_wrap,
    input  logic               commit_valid,
    input  logic [DATA_W-1:0]  commit_pc,
    input  logic               commit_regwrite,
    input  logic [REG_W-1:0]   commit_reg,
    input  logic [DATA_W-1:0]  commit_wdata,
    input  logic               commit_memwrite,
    input  logic [DATA_W-1:0]  commit_addr,
    input  logic [DATA_W-1:0]  commit_mdata,
    input  logic               halt,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [ENTRY_W-1:0] rd_entry,
    output logic [CNT_W-1:0]   inst_count,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [1:0]         state,
    output logic               overflow,
    output logic               timed_out,
    output logic               done
);

    state_t              state_q;
    logic                push;
    logic                fifo_ovf;
    logic                timeout_hit;
    logic [1:0]          kind;
    logic [REG_W-1:0]    ent_reg;
    logic [DATA_W-1:0]   ent_a;
    logic [DATA_W-1:0]   ent_b;
    logic [ENTRY_W-1:0]  entry;

    always_comb begin
        kind    = KIND_NOP;
        ent_reg = '0;
        ent_a   = '0;
        ent_b   = '0;
        if (halt) begin
            kind = KIND_HALT;
        end else if (commit_regwrite) begin
            kind    = KIND_REG;
            ent_reg = commit_reg;
            ent_a   = commit_wdata;
        end else if (commit_memwrite) begin
            kind  = KIND_MEM;
            ent_a = commit_addr;
            ent_b = commit_mdata;
        end
    end

    assign entry       = {kind, inst_count, commit_pc, ent_reg, ent_a, ent_b};
    assign push        = commit_valid & (state_q == ST_RUN);
    assign timeout_hit = (cycle_count == CNT_W'(TIMEOUT - 1));
    assign state       = state_q;
    assign done        = (state_q == ST_DONE);

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wrap     (cfg_wrap),
        .s_tvalid (push),
        .s_tdata  (entry),
        .m_tvalid (rd_valid),
        .m_tready (rd_ready),
        .m_tdata  (rd_entry),
        .overflow (fifo_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            inst_count  <= '0;
            cycle_count <= '0;
            overflow    <= 1'b0;
            timed_out   <= 1'b0;
        end else begin
            overflow <= overflow | fifo_ovf;
            case (state_q)
                ST_RUN: begin
                    cycle_count <= cycle_count + CNT_W'(1);
                    if (push && inst_count != '1) begin
                        inst_count <= inst_count + CNT_W'(1);
                    end
                    // A halt retiring on the timeout cycle wins; the timeout flag is only for runaways.
                    if (push && halt) begin
                        state_q <= ST_DRAIN;
                    end else if (timeout_hit) begin
                        timed_out <= 1'b1;
                        state_q   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!rd_valid) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_capture.sv
// tb/tb_trace_capture.sv - self-checking bench for trace_capture against a queue-based reference model
module tb_trace_capture;

    localparam int DW    = 16;
    localparam int RW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 32;
    localparam int TO    = 20;
    localparam int EW    = 2 + CW + 3 * DW + RW;

    logic          clk;
    logic          rst_n;
    logic          cfg_wrap;
    logic          commit_valid;
    logic [DW-1:0] commit_pc;
    logic          commit_regwrite;
    logic [RW-1:0] commit_reg;
    logic [DW-1:0] commit_wdata;
    logic          commit_memwrite;
    logic [DW-1:0] commit_addr;
    logic [DW-1:0] commit_mdata;
    logic          halt;
    logic          rd_valid;
    logic          rd_ready;
    logic [EW-1:0] rd_entry;
    logic [CW-1:0] inst_count;
    logic [CW-1:0] cycle_count;
    logic [1:0]    state;
    logic          overflow;
    logic          timed_out;
    logic          done;

    trace_capture #(
        .DATA_W  (DW),
        .REG_W   (RW),
        .DEPTH   (DEPTH),
        .CNT_W   (CW),
        .TIMEOUT (TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_wrap        (cfg_wrap),
        .commit_valid    (commit_valid),
        .commit_pc       (commit_pc),
        .commit_regwrite (commit_regwrite),
        .commit_reg      (commit_reg),
        .commit_wdata    (commit_wdata),
        .commit_memwrite (commit_memwrite),
        .commit_addr     (commit_addr),
        .commit_mdata    (commit_mdata),
        .halt            (halt),
        .rd_valid        (rd_valid),
        .rd_ready        (rd_ready),
        .rd_entry        (rd_entry),
        .inst_count      (inst_count),
        .cycle_count     (cycle_count),
        .state           (state),
        .overflow        (overflow),
        .timed_out       (timed_out),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the buffer is just a queue of entries, states are 0/1/2 integers.
    logic [EW-1:0] mq[$];
    int            m_state;
    logic [CW-1:0] m_inst;
    logic [CW-1:0] m_cycle;
    bit            m_ovf;
    bit            m_to;
    bit            check_en;
    logic [EW-1:0] dut_log[$];
    int            checks;
    int            failures;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] make_entry();
        logic [1:0]    k;
        logic [RW-1:0] r;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        r = '0;
        a = '0;
        b = '0;
        if (halt) k = 2'd3;
        else if (commit_regwrite) begin
            k = 2'd1;
            r = commit_reg;
            a = commit_wdata;
        end else if (commit_memwrite) begin
            k = 2'd2;
            a = commit_addr;
            b = commit_mdata;
        end else k = 2'd0;
        return {k, m_inst, commit_pc, r, a, b};
    endfunction

    task automatic model_step();
        int            old_size;
        bit            pop;
        bit            push;
        logic [EW-1:0] e;
        old_size = mq.size();
        if (!rst_n) begin
            mq.delete();
            m_state = 0;
            m_inst  = '0;
            m_cycle = '0;
            m_ovf   = 1'b0;
            m_to    = 1'b0;
            return;
        end
        pop  = rd_ready && (old_size > 0);
        push = commit_valid && (m_state == 0);
        e    = make_entry();
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(e);
            else begin
                m_ovf = 1'b1;
                if (cfg_wrap) begin
                    void'(mq.pop_front());
                    mq.push_back(e);
                end
            end
        end
        if (m_state == 0) begin
            if (push && m_inst != '1) m_inst = m_inst + 1;
            if (push && halt) m_state = 1;
            else if (m_cycle == CW'(TO - 1)) begin
                m_to    = 1'b1;
                m_state = 1;
            end
            m_cycle = m_cycle + 1;
        end else if (m_state == 1) begin
            if (old_size == 0) m_state = 2;
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("rd_valid", rd_valid, mq.size() != 0);
            if (mq.size() != 0) chk("rd_entry", rd_entry, mq[0]);
            chk("inst_count", inst_count, m_inst);
            chk("cycle_count", cycle_count, m_cycle);
            chk("state", state, m_state);
            chk("overflow", overflow, m_ovf);
            chk("timed_out", timed_out, m_to);
            chk("done", done, m_state == 2);
            if (rd_valid && rd_ready) dut_log.push_back(rd_entry);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic idle_inputs();
        commit_valid    = 1'b0;
        commit_pc       = '0;
        commit_regwrite = 1'b0;
        commit_reg      = '0;
        commit_wdata    = '0;
        commit_memwrite = 1'b0;
        commit_addr     = '0;
        commit_mdata    = '0;
        halt            = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        step();
        rst_n    = 1'b1;
        check_en = 1'b1;
        dut_log.delete();
    endtask

    task automatic nop_commits(input int n);
        for (int i = 0; i < n; i++) begin
            idle_inputs();
            commit_valid = 1'b1;
            commit_pc    = DW'(i * 2);
            step();
        end
        idle_inputs();
    endtask

    task automatic wait_timeout(input int budget);
        int n;
        n = 0;
        while (timed_out !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("timeout_reached", timed_out, 1'b1);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("done_reached", done, 1'b1);
    endtask

    task automatic check_inums(input string nm, input int first, input int n);
        chk({nm, "_count"}, dut_log.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < dut_log.size()) chk({nm, "_inum"}, dut_log[i][EW-3 -: CW], first + i);
        end
    endtask

    initial begin
        logic [EW-1:0] first_exp;
        logic [1:0]    kinds [4];
        checks   = 0;
        failures = 0;
        check_en = 1'b0;
        rst_n    = 1'b0;
        cfg_wrap = 1'b1;
        rd_ready = 1'b0;
        idle_inputs();
        step();

        // Reset state.
        do_reset();
        chk("reset_rd_valid", rd_valid, 1'b0);
        chk("reset_state", state, 2'd0);
        chk("reset_inst", inst_count, 0);

        // REG, MEM, NOP, HALT with consumer always ready.
        rd_ready = 1'b1;
        commit_valid = 1'b1; commit_pc = 16'h0000; commit_regwrite = 1'b1;
        commit_reg = 4'd1; commit_wdata = 16'h0005;
        step();
        commit_regwrite = 1'b0; commit_memwrite = 1'b1; commit_pc = 16'h0002;
        commit_addr = 16'h0010; commit_mdata = 16'h00AA;
        step();
        commit_memwrite = 1'b0; commit_pc = 16'h0004;
        step();
        halt = 1'b1; commit_pc = 16'h0006;
        step();
        idle_inputs();
        wait_done(20);
        kinds = '{2'd1, 2'd2, 2'd0, 2'd3};
        check_inums("basic", 0, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < dut_log.size()) chk("basic_kind", dut_log[i][EW-1 -: 2], kinds[i]);
        end
        first_exp = {2'd1, 32'd0, 16'h0000, 4'd1, 16'h0005, 16'h0000};
        if (dut_log.size() > 0) chk("basic_reg_entry", dut_log[0], first_exp);
        chk("basic_inst_count", inst_count, 4);
        chk("basic_state_done", state, 2'd2);

        // Wrap mode overflow, then timeout and drain.
        cfg_wrap = 1'b1; rd_ready = 1'b0;
        do_reset();
        nop_commits(6);
        wait_timeout(40);
        chk("wrap_cycle_count", cycle_count, 20);
        chk("wrap_overflow", overflow, 1'b1);
        chk("wrap_state_drain", state, 2'd1);
        step();
        chk("wrap_hold_drain", state, 2'd1);
        rd_ready = 1'b1;
        wait_done(20);
        check_inums("wrap", 2, 4);

        // Drop mode overflow.
        cfg_wrap = 1'b0; rd_ready = 1'b0;
        do_reset();
        nop_commits(6);
        chk("drop_overflow", overflow, 1'b1);
        chk("drop_inst_count", inst_count, 6);
        wait_timeout(40);
        rd_ready = 1'b1;
        wait_done(20);
        check_inums("drop", 0, 4);

        // Full buffer with simultaneous push and pop.
        cfg_wrap = 1'b0; rd_ready = 1'b0;
        do_reset();
        nop_commits(4);
        commit_valid = 1'b1; commit_pc = 16'h0100; rd_ready = 1'b1;
        step();
        idle_inputs(); rd_ready = 1'b0;
        chk("fullpp_overflow", overflow, 1'b0);
        wait_timeout(40);
        rd_ready = 1'b1;
        wait_done(20);
        check_inums("fullpp", 0, 5);
        chk("fullpp_overflow_end", overflow, 1'b0);

        // Reset mid-operation with entries buffered and a commit in the reset cycle.
        cfg_wrap = 1'b1; rd_ready = 1'b0;
        do_reset();
        nop_commits(3);
        rst_n = 1'b0; commit_valid = 1'b1;
        step();
        rst_n = 1'b1; idle_inputs();
        chk("midrst_rd_valid", rd_valid, 1'b0);
        chk("midrst_inst", inst_count, 0);
        chk("midrst_cycle", cycle_count, 0);
        chk("midrst_state", state, 2'd0);
        chk("midrst_overflow", overflow, 1'b0);

        // Randomised episodes checked cycle by cycle against the model.
        for (int ep = 0; ep < 10; ep++) begin
            cfg_wrap = 1'($urandom_range(0, 1));
            do_reset();
            for (int c = 0; c < 50; c++) begin
                commit_valid    = ($urandom_range(0, 2) != 0);
                commit_pc       = DW'($urandom);
                commit_regwrite = 1'($urandom_range(0, 1));
                commit_reg      = RW'($urandom);
                commit_wdata    = DW'($urandom);
                commit_memwrite = 1'($urandom_range(0, 1));
                commit_addr     = DW'($urandom);
                commit_mdata    = DW'($urandom);
                halt            = ($urandom_range(0, 14) == 0);
                rd_ready        = 1'($urandom_range(0, 1));
                rst_n           = ($urandom_range(0, 59) != 0);
                cfg_wrap        = ($urandom_range(0, 19) == 0) ? ~cfg_wrap : cfg_wrap;
                step();
            end
            rst_n = 1'b1;
            idle_inputs();
            rd_ready = 1'b1;
            for (int c = 0; c < 30; c++) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
